// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: byte FIFO feeding an 11-bit frame serialiser on generated ps2_clk/ps2_data.
// Latency: a byte pushed into an empty idle block shows its start bit on ps2_data two clk edges later.
// Backpressure: ready_out drops while the FIFO is full; frames are paced by CLK_DIV and GAP only.

// Small synchronous FIFO with combinational read of the head entry.
module ps2_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         full, do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty    = (wr_q == rd_q);
  assign push_rdy = !full;
  assign do_push  = push_vld && !full;
  assign do_pop   = pop && !empty;
  assign pop_dat  = mem_q[rd_q[AW-1:0]];

  // Pointer advance; a push and a pop in one cycle both move.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_dat;
  end
endmodule

module ps2_device_tx #(
  parameter int CLK_DIV    = 50,
  parameter int GAP        = 200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW, ST_GAP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [DW-1:0]   div_q, div_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [10:0]     frame_q, frame_d;
  logic            ps2_clk_q, ps2_clk_d;
  logic            ps2_data_q, ps2_data_d;
  logic            busy_q, busy_d;
  logic            fifo_pop, fifo_empty;
  logic [7:0]      fifo_dat;

  ps2_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (valid_in),
    .push_rdy (ready_out),
    .push_dat (data_in),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .empty    (fifo_empty)
  );

  // Next-state logic plus line values; the lines are registered from the current
  // state so they trail the state by one cycle and never see input paths.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    div_d      = div_q;
    gap_d      = gap_q;
    frame_d    = frame_q;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          // stop, odd parity, d7..d0, start: bit 0 goes out first
          frame_d  = {1'b1, ~^fifo_dat, fifo_dat, 1'b0};
          idx_d    = 4'd0;
          div_d    = '0;
          state_d  = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d   = '0;
          state_d = ST_LOW;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_LOW: begin
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d = '0;
          if (idx_q < 4'd10) begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_HIGH;
          end else begin
            gap_d   = '0;
            state_d = ST_GAP;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP - 1)) state_d = ST_IDLE;
        else                       gap_d   = gap_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    ps2_clk_d  = (state_q != ST_LOW);
    // frame_q/idx_q only change on HIGH entry, so data holds through LOW.
    ps2_data_d = (state_q == ST_HIGH || state_q == ST_LOW) ? frame_q[idx_q] : 1'b1;
    busy_d     = (state_q != ST_IDLE) || !fifo_empty;
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      div_q      <= '0;
      gap_q      <= '0;
      frame_q    <= '1;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      frame_q    <= frame_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      busy_q     <= busy_d;
    end
  end

  assign ps2_clk  = ps2_clk_q;
  assign ps2_data = ps2_data_q;
  assign busy     = busy_q;
endmodule

// File: doc/ps2_device_tx.md
# ps2_device_tx

Device-side PS/2 transmitter: it accepts scan-code bytes on a valid/ready interface, buffers them in a small FIFO, and serialises each byte as an 11-bit PS/2 frame on its own generated `ps2_clk`/`ps2_data` lines. It is the keyboard end of the link consumed by `ps2_keyboard`. It drives that receiver in simulation and loopback tests, so keyboard input can be exercised without external stimulus.

## Interface
- `CLK_DIV`, default 50: number of `clk` cycles in each half-period of `ps2_clk`. Must be ≥ 2.
- `GAP`, default 200: number of idle `clk` cycles (both lines high) enforced after each frame's last low phase.
- `FIFO_DEPTH`, default 8: byte FIFO depth. Must be a power of two, ≥ 2.
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  synchronous reset, active-high.
- `data_in`  in  8  scan-code byte to send.
- `valid_in`  in  1  `data_in` is valid.
- `ready_out`  out  1  FIFO can accept a byte.
- `ps2_clk`  out  1  generated PS/2 clock. Idles high.
- `ps2_data`  out  1  PS/2 data line. Idles high.
- `busy`  out  1  a frame is in progress, the post-frame gap is running, or the FIFO is non-empty.

## Operation
- **Push.** A byte is written when `valid_in && ready_out` at a rising `clk` edge. `ready_out = !full`.
  - A push while full is dropped with no side effect.
  - A push and a pop in the same cycle both take effect; occupancy is unchanged.
- **Frame format.** 11 bits, in this order:
  - start bit = 0
  - d0..d7, LSB first
  - odd parity, `~^data`
  - stop bit = 1
- **State machine states:** IDLE, HIGH, LOW, GAP. The machine also holds a 4-bit bit index (0..10), a divider counter of width `$clog2(CLK_DIV)`, and a GAP counter.
- **IDLE.**
  - Outputs: `ps2_clk=1`, `ps2_data=1`.
  - If the FIFO is non-empty: pop the head, load the 11-bit shift frame, set index to 0, go to HIGH.
- **HIGH.**
  - Outputs: `ps2_clk=1`, `ps2_data=frame[index]`.
  - After `CLK_DIV` cycles, go to LOW.
- **LOW.**
  - Outputs: `ps2_clk=0`, `ps2_data` held unchanged.
  - After `CLK_DIV` cycles: if index < 10, increment index and go to HIGH; else go to GAP.
- **GAP.**
  - Outputs: `ps2_clk=1`, `ps2_data=1`.
  - After `GAP` cycles, go to IDLE.
- **Bit alignment.** `ps2_data` changes only at entry to HIGH, so it is stable for a full half-period before each falling edge of `ps2_clk`. The receiver samples on that falling edge.
- **Registered outputs.** `ps2_clk` and `ps2_data` are registered; there are no combinational paths from inputs to them.
- **Reset.** At any time, including mid-frame, reset has the following effect at the next edge:
  - state becomes IDLE and the FIFO is emptied;
  - the partial frame is abandoned, with no completion;
  - outputs are `ps2_clk=1`, `ps2_data=1`, `ready_out=1`, `busy=0`.

## Timing
- **Reset values:** `ps2_clk=1`, `ps2_data=1`, `ready_out=1`, `busy=0`.
- **First start bit.** A byte pushed into an empty, idle block at edge T is popped at edge T+1. HIGH is entered at edge T+2, with `ps2_data=0` visible from T+2.
- **Bit period** = `2*CLK_DIV` cycles. With HIGH entered at edge S, the falling edge of bit k occurs at S + `CLK_DIV` + k·2·`CLK_DIV`.
- **Frame length** = `22*CLK_DIV` cycles, followed by `GAP` cycles.
- **Back-to-back bytes.** The next HIGH begins `22*CLK_DIV + GAP + 1` cycles after the previous HIGH entry: the extra cycle is the IDLE pop.
- **`busy`** rises the cycle after the first accepted push. It falls the cycle after GAP ends with the FIFO empty.
- **`ready_out`** falls the cycle after the push that fills the FIFO. It rises the cycle after the pop that frees an entry.

## Test plan
All scenarios use `CLK_DIV=4`, `GAP=10`, `FIFO_DEPTH=8`.
- **Single byte 0x1C.**
  - Push 0x1C.
  - At each `ps2_clk` falling edge, require `ps2_data` to read 0, 0,0,1,1,1,0,0,0, 0, 1 (start, d0..d7, parity, stop).
  - Require the first falling edge 6 cycles after the push (T+2+4).
  - Require `busy` to fall 88+10 cycles after HIGH entry.
- **Back-to-back 0xF0 then 0x1C.**
  - Push both on consecutive cycles.
  - Require the 0xF0 frame to read 0, 0,0,0,0,1,1,1,1, 1, 1.
  - Require the second start bit exactly 99 cycles after the first HIGH entry, with both lines high for the 10 gap cycles.
- **FIFO full.**
  - Push 9 bytes (0x01..0x09) while held in reset-free IDLE; the first pop occurs, so 8 or more are accepted.
  - Hold `valid_in` while `ready_out=0`.
  - Require the dropped byte to never appear.
  - Require frames in push order, with no duplicates.
- **Simultaneous push/pop at full.** With the FIFO full, present a push in the same cycle as an IDLE pop. Require the push to be rejected, since `ready_out=0`, and occupancy to drop by 1.
- **Reset mid-frame.**
  - Assert `rst` for one cycle during bit 4 (LOW phase) of 0x55.
  - Require `ps2_clk=ps2_data=1` the next cycle, `busy=0`, `ready_out=1`.
  - Require no further edges until a new push.
- **Loopback.**
  - Connect to `ps2_keyboard` (`resetn = ~rst`) and send 0x1C, 0xF0, 0x1C.
  - Require the receiver to capture 0x1C, 0xF0, 0x1C, in order and with valid parity.
